// File: rtl/program_loader.sv
// program_loader: receives a header byte plus LO/HI byte pairs from a host
// link and writes assembled instructions into program memory while holding the CPU.
// Ports: clock, reset (sync, active-high), start, in_data/in_valid/in_ready
// byte stream, mem_we/mem_addr/mem_din memory write port, cpu_hold, busy,
// done (one-cycle pulse), error (sticky checksum failure).
// Macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module program_loader #(
    parameter int ADDR_LEN        = 4,
    parameter int INSTRUCTION_LEN = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       mem_we,
    output logic [ADDR_LEN-1:0]        mem_addr,
    output logic [INSTRUCTION_LEN-1:0] mem_din,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LO,
        S_HI,
        S_WR,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_LEN-1:0]        addr_q;
    logic [ADDR_LEN-1:0]        last_q;
    logic [7:0]                 lo_q;
    logic [ADDR_LEN-1:0]        mem_addr_q;
    logic [INSTRUCTION_LEN-1:0] mem_din_q;
    logic                       ready_s;
    logic                       xfer;
    logic                       last_word;

    assign xfer      = in_valid && ready_s;
    assign last_word = (addr_q == last_q);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_HDR;
            S_HDR:  if (xfer)  state_d = S_LO;
            S_LO:   if (xfer)  state_d = S_HI;
            S_HI:   if (xfer)  state_d = S_WR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_WR:   state_d = last_word ? S_CHK : S_LO;
            S_CHK:  if (xfer)  state_d = S_DONE;
`else
            S_WR:   state_d = last_word ? S_DONE : S_LO;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; everything is forced low while reset is asserted so that
    // the reset cycle itself can never issue a memory write.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            S_HDR, S_LO, S_HI: ready_s = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:             ready_s = 1'b1;
`endif
            default:           ready_s = 1'b0;
        endcase
        in_ready = ready_s && !reset;
        mem_we   = (state_q == S_WR) && !reset;
        done     = (state_q == S_DONE) && !reset;
        cpu_hold = (state_q != S_IDLE) && !reset;
        busy     = cpu_hold;
        mem_addr = reset ? '0 : mem_addr_q;
        mem_din  = reset ? '0 : mem_din_q;
    end

    // Datapath. The write port registers load on the HI transfer so they
    // present the word during WR and then hold it until the next word.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            last_q     <= '0;
            lo_q       <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) addr_q <= '0;
                S_HDR:  if (xfer)  last_q <= in_data[ADDR_LEN-1:0];
                S_LO:   if (xfer)  lo_q   <= in_data;
                S_HI: begin
                    if (xfer) begin
                        mem_addr_q <= addr_q;
                        mem_din_q  <= {in_data[INSTRUCTION_LEN-9:0], lo_q};
                    end
                end
                S_WR:   if (!last_word) addr_q <= addr_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] acc_q;
    logic       err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if (xfer) begin
            if (state_q == S_CHK) begin
                if (in_data != acc_q) err_q <= 1'b1;
            end else begin
                acc_q <= acc_q ^ in_data;
            end
        end
    end

    assign error = err_q && !reset;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads against a queue-based write model.
// Covers basic, stalled, full-memory, start-while-busy, mid-load reset, checksum.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AL = 4;
    localparam int IL = 10;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clock = 1'b0;
    logic          reset, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, cpu_hold, busy, done, error;
    logic [AL-1:0] mem_addr;
    logic [IL-1:0] mem_din;

    program_loader #(.ADDR_LEN(AL), .INSTRUCTION_LEN(IL)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AL-1:0] a;
        logic [IL-1:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        e;
    int         words[$];
    logic [7:0] bytes[$];
    logic [IL-1:0] dut_mem[16];
    int         wr_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process: every write must be the next one the model predicts.
    always @(negedge clock) begin
        checks++;
        if (busy !== cpu_hold) begin
            errors++;
            $display("FAIL busy_vs_hold actual=%b required=%b", busy, cpu_hold);
        end
        if (mem_we === 1'b1) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_wr actual=%b required=0", in_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_write actual=%0h:%0h required=none", mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_din !== e.d) begin
                    errors++;
                    $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                             mem_addr, mem_din, e.a, e.d);
                end
            end
            dut_mem[mem_addr] = mem_din;
            wr_count++;
        end
    end

    // Build the byte stream for `words` and queue the first push_n writes.
    task automatic prep(input logic [7:0] hdr, input logic [7:0] garb,
                        input bit bad, input int push_n);
        logic [7:0] x;
        logic [IL-1:0] w;
        bytes.delete();
        exp_q.delete();
        wr_count = 0;
        for (int i = 0; i < 16; i++) dut_mem[i] = '0;
        bytes.push_back(hdr);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i][IL-1:0];
            bytes.push_back(w[7:0]);
            bytes.push_back(garb | {6'b0, w[9:8]});
        end
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bytes.push_back(bad ? (x ^ 8'h5A) : x);
`endif
        for (int i = 0; i < push_n; i++) begin
            e.a = i[AL-1:0];
            e.d = words[i][IL-1:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic outs_zero(input string name);
        chk(name, {in_ready, mem_we, mem_addr, mem_din, cpu_hold, busy, done, error}, 0);
    endtask

    // stall: in_valid pattern 1,0,0,1; poke: start pulsed in LO;
    // abort_at: assert reset once that many bytes were accepted.
    task automatic run_load(input bit stall, input bit poke, input int abort_at,
                            input bit exp_err, output int done_cyc);
        int idx;
        int cyc;
        bit fin;
        idx = 0;
        fin = 0;
        done_cyc = -1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 400) begin
            in_valid = (idx < bytes.size()) &&
                       (!stall || (cyc % 4 == 0) || (cyc % 4 == 3));
            in_data  = (idx < bytes.size()) ? bytes[idx] : 8'h00;
            start    = poke && (cyc == 2);
            if (abort_at > 0 && idx == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (reset) begin
                outs_zero("reset_cycle_outs");
                fin = 1;
            end else begin
                if (cyc == 1) begin
                    chk("error_cleared", error, 0);
                    chk("busy_on_start", busy, 1);
                end
                if (in_valid && in_ready) idx++;
                if (done) begin
                    chk("error_at_done", error, exp_err);
                    done_cyc = cyc;
                    fin = 1;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL load_timeout actual=%0d required=<400", cyc);
        end
        if (done_cyc > 0) begin
            @(negedge clock);
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("error_sticky", error, exp_err);
            @(posedge clock); #1;
        end
    endtask

    task automatic basic_words();
        words.delete();
        words.push_back(32'h234);
        words.push_back(32'h3CD);
    endtask

    int dc;

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(posedge clock); #1;
        @(negedge clock);
        outs_zero("reset_outs");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        outs_zero("post_reset_outs");
        @(posedge clock); #1;

        // Basic load: bytes 01 34 02 CD 03 (+F9)
        basic_words();
        prep(8'h01, 8'h00, 1'b0, 2);
        chk("basic_ck_byte", bytes[bytes.size()-1], (CK == 1) ? 8'hF9 : 8'h03);
        run_load(1'b0, 1'b0, 0, 1'b0, dc);
        chk("basic_done_cyc", dc, 8 + CK);
        chk("basic_mem0", dut_mem[0], 10'h234);
        chk("basic_mem1", dut_mem[1], 10'h3CD);
        chk("basic_wr_count", wr_count, 2);

        // Stalled load
        basic_words();
        prep(8'h01, 8'h00, 1'b0, 2);
        run_load(1'b1, 1'b0, 0, 1'b0, dc);
        chk("stall_slower", dc > 8 + CK, 1);
        chk("stall_mem0", dut_mem[0], 10'h234);
        chk("stall_mem1", dut_mem[1], 10'h3CD);
        chk("stall_left", exp_q.size(), 0);

        // Start pulsed while busy
        basic_words();
        prep(8'h01, 8'h00, 1'b0, 2);
        run_load(1'b0, 1'b1, 0, 1'b0, dc);
        chk("poke_done_cyc", dc, 8 + CK);
        chk("poke_mem1", dut_mem[1], 10'h3CD);

        // Full memory, upper header/HI bits set
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back((i * 71 + 32'h155) & 32'h3FF);
        prep(8'hFF, 8'hFC, 1'b0, 16);
        run_load(1'b0, 1'b0, 0, 1'b0, dc);
        chk("full_done_cyc", dc, 50 + CK);
        chk("full_wr_count", wr_count, 16);
        for (int i = 0; i < 16; i++)
            chk("full_mem", dut_mem[i], words[i][IL-1:0]);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Wrong checksum: error set, sticky until next start
        basic_words();
        prep(8'h01, 8'h00, 1'b1, 2);
        run_load(1'b0, 1'b0, 0, 1'b1, dc);
        chk("bad_done_cyc", dc, 9);
        @(negedge clock);
        chk("bad_err_held", error, 1);
        @(posedge clock); #1;
`endif

        // Reset in HI of word 3
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back((i * 29 + 32'h0A7) & 32'h3FF);
        prep(8'h0F, 8'h00, 1'b0, 3);
        run_load(1'b0, 1'b0, 8, 1'b0, dc);
        chk("abort_no_done", dc, -1);
        @(negedge clock);
        outs_zero("abort_next_outs");
        @(posedge clock); #1;
        chk("abort_wr_count", wr_count, 3);
        chk("abort_left", exp_q.size(), 0);

        // Fresh load after reset
        basic_words();
        prep(8'h01, 8'h00, 1'b0, 2);
        run_load(1'b0, 1'b0, 0, 1'b0, dc);
        chk("reload_done_cyc", dc, 8 + CK);
        chk("reload_mem0", dut_mem[0], 10'h234);
        chk("reload_mem1", dut_mem[1], 10'h3CD);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
